alu_sequencer: RTL and testbench

//  Instruction sequencer and 8x8 register file on the initiator side of the 8-bit ALU.

---
 rtl/alu_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Instruction sequencer and 8x8 register file driving an external 8-bit ALU.
// Instructions go IDLE -> EXEC -> WB; ALU operands are launched on the falling clock edge.
module alu_sequencer #(
   parameter int unsigned EXEC_WAIT = 1,
   parameter int unsigned DATA_W    = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [15:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic              reg_wr_en,
   input  logic [2:0]        reg_wr_addr,
   input  logic [DATA_W-1:0] reg_wr_data,
   input  logic [2:0]        reg_rd_addr,
   output logic [DATA_W-1:0] reg_rd_data,
   output logic [4:0]        alu_op,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [2:0]        alu_im,
   input  logic [DATA_W-1:0] alu_res,
   input  logic              alu_cf,
   input  logic              alu_zf,
   input  logic              alu_sf,
   input  logic              alu_of,
   output logic [3:0]        flags,
   output logic              done,
   output logic              illegal,
   output logic [DATA_W-1:0] show_data,
   output logic              show_valid
);

   localparam int unsigned CNT_W = (EXEC_WAIT > 1) ? $clog2(EXEC_WAIT) : 1;
   localparam int unsigned NUM_REGS = 8;

   localparam logic [4:0] OP_NOP   = 5'b00000;
   localparam logic [4:0] OP_MOV   = 5'b00110;
   localparam logic [4:0] OP_NOT   = 5'b01000;
   localparam logic [4:0] OP_SHOWR = 5'b11111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_e;

   typedef struct packed {
      logic [4:0] op;
      logic [2:0] rd;
      logic [2:0] rs;
      logic [2:0] im;
   } ir_t;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   ir_t                 ir_q, ir_d;
   logic [DATA_W-1:0]   rf_q [NUM_REGS];
   logic [DATA_W-1:0]   rf_d [NUM_REGS];
   logic [3:0]          flags_q, flags_d;
   logic                done_q, done_d;
   logic                illegal_q, illegal_d;
   logic                show_valid_q, show_valid_d;
   logic [DATA_W-1:0]   show_data_q, show_data_d;

   logic [4:0]          alu_op_q, alu_op_d;
   logic [DATA_W-1:0]   alu_in1_q, alu_in1_d;
   logic [DATA_W-1:0]   alu_in2_q, alu_in2_d;
   logic [2:0]          alu_im_q, alu_im_d;

   logic                accept;
   logic                last_exec;
   logic                op_writes;
   logic                op_sets_flags;
   logic                op_legal;

   // Reserved instruction bits carry no meaning.
   logic                unused_instr_bits;
   assign unused_instr_bits = ^instr[1:0];

   // Handshake and op-class decode of the latched instruction.
   always_comb begin
      accept        = instr_valid && (state_q == S_IDLE);
      last_exec     = (cnt_q == CNT_W'(EXEC_WAIT - 1));
      op_writes     = (ir_q.op inside {[5'd1:5'd6], [5'd8:5'd14]});
      op_sets_flags = op_writes && (ir_q.op != OP_MOV) && (ir_q.op != OP_NOT);
      op_legal      = op_writes || (ir_q.op == OP_NOP) || (ir_q.op == OP_SHOWR);
   end

   // Next-state, register-file writes and WB pulses.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ir_d         = ir_q;
      rf_d         = rf_q;
      flags_d      = flags_q;
      done_d       = 1'b0;
      illegal_d    = 1'b0;
      show_valid_d = 1'b0;
      show_data_d  = show_data_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               ir_d    = ir_t'(instr[15:2]);
               cnt_d   = '0;
               state_d = S_EXEC;
            end else if (reg_wr_en) begin
               rf_d[reg_wr_addr] = reg_wr_data;
            end
         end
         S_EXEC: begin
            if (last_exec) begin
               state_d   = S_WB;
               done_d    = 1'b1;
               illegal_d = !op_legal;
               if (op_writes) begin
                  rf_d[ir_q.rd] = alu_res;
               end
               if (op_sets_flags) begin
                  flags_d = {alu_cf, alu_zf, alu_sf, alu_of};
               end
               if (ir_q.op == OP_SHOWR) begin
                  show_valid_d = 1'b1;
                  show_data_d  = rf_q[ir_q.rd];
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WB: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         ir_q         <= '0;
         rf_q         <= '{default: '0};
         flags_q      <= '0;
         done_q       <= 1'b0;
         illegal_q    <= 1'b0;
         show_valid_q <= 1'b0;
         show_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ir_q         <= ir_d;
         rf_q         <= rf_d;
         flags_q      <= flags_d;
         done_q       <= done_d;
         illegal_q    <= illegal_d;
         show_valid_q <= show_valid_d;
         show_data_q  <= show_data_d;
      end
   end

   // ALU launch: operands change while the clock is low so the ALU settles before capture.
   always_comb begin
      alu_op_d  = alu_op_q;
      alu_in1_d = alu_in1_q;
      alu_in2_d = alu_in2_q;
      alu_im_d  = alu_im_q;
      if ((state_q == S_EXEC) && (cnt_q == '0)) begin
         alu_op_d  = ir_q.op;
         alu_in1_d = rf_q[ir_q.rd];
         alu_in2_d = rf_q[ir_q.rs];
         alu_im_d  = ir_q.im;
      end else if (state_q != S_EXEC) begin
         alu_op_d  = OP_NOP;
      end
   end

   always_ff @(negedge clock) begin
      if (reset) begin
         alu_op_q  <= OP_NOP;
         alu_in1_q <= '0;
         alu_in2_q <= '0;
         alu_im_q  <= '0;
      end else begin
         alu_op_q  <= alu_op_d;
         alu_in1_q <= alu_in1_d;
         alu_in2_q <= alu_in2_d;
         alu_im_q  <= alu_im_d;
      end
   end

   assign instr_ready = (state_q == S_IDLE);
   assign reg_rd_data = rf_q[reg_rd_addr];
   assign alu_op      = alu_op_q;
   assign alu_in1     = alu_in1_q;
   assign alu_in2     = alu_in2_q;
   assign alu_im      = alu_im_q;
   assign flags       = flags_q;
   assign done        = done_q;
   assign illegal     = illegal_q;
   assign show_data   = show_data_q;
   assign show_valid  = show_valid_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU on the far side.
module tb_alu_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        reg_wr_en;
   logic [2:0]  reg_wr_addr;
   logic [7:0]  reg_wr_data;
   logic [2:0]  reg_rd_addr;
   logic [7:0]  reg_rd_data;
   logic [4:0]  alu_op;
   logic [7:0]  alu_in1;
   logic [7:0]  alu_in2;
   logic [2:0]  alu_im;
   logic [7:0]  alu_res;
   logic        alu_cf, alu_zf, alu_sf, alu_of;
   logic [3:0]  flags;
   logic        done, illegal, show_valid;
   logic [7:0]  show_data;

   int errors = 0;
   int checks = 0;

   alu_sequencer #(.EXEC_WAIT(1), .DATA_W(8)) dut (
      .clock(clock), .reset(reset),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
      .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
      .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_im(alu_im),
      .alu_res(alu_res), .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
      .flags(flags), .done(done), .illegal(illegal),
      .show_data(show_data), .show_valid(show_valid)
   );

   always #5 clock = ~clock;

   // Behavioural ALU: ADD/SUB set carry/overflow, logic ops clear them, 01001 is shift-left by im.
   logic [8:0] m_wide;
   always_comb begin
      m_wide  = '0;
      alu_res = '0;
      alu_cf  = 1'b0;
      alu_of  = 1'b0;
      case (alu_op)
         5'd1: begin
            m_wide  = {1'b0, alu_in1} + {1'b0, alu_in2};
            alu_res = m_wide[7:0];
            alu_cf  = m_wide[8];
            alu_of  = (alu_in1[7] == alu_in2[7]) && (alu_res[7] != alu_in1[7]);
         end
         5'd2: alu_res = alu_in1 & alu_in2;
         5'd3: begin
            alu_res = alu_in1 - alu_in2;
            alu_cf  = alu_in1 < alu_in2;
            alu_of  = (alu_in1[7] != alu_in2[7]) && (alu_res[7] != alu_in1[7]);
         end
         5'd4: alu_res = alu_in1 | alu_in2;
         5'd5: alu_res = alu_in1 ^ alu_in2;
         5'd6: alu_res = alu_in2;
         5'd8: alu_res = ~alu_in1;
         5'd9: begin
            m_wide  = {1'b0, alu_in1} << alu_im;
            alu_res = m_wide[7:0];
            alu_cf  = m_wide[8];
         end
         default: alu_res = '0;
      endcase
      alu_zf = (alu_res == 8'h00);
      alu_sf = alu_res[7];
   end

   typedef struct {
      logic [15:0] ins;
      logic [2:0]  addr;
      logic [7:0]  val;
      logic [3:0]  flg;
      logic        ill;
      logic        shw;
      logic [7:0]  sdata;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] im,
                                      input logic [1:0] rsv);
      return {op, rd, rs, im, rsv};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [2:0] a, input logic [7:0] d);
      reg_wr_en   = 1'b1;
      reg_wr_addr = a;
      reg_wr_data = d;
      @(posedge clock); #1;
      reg_wr_en   = 1'b0;
   endtask

   task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
      reg_rd_addr = a;
      #1;
      d = reg_rd_data;
   endtask

   // Issues one instruction and returns cycles from accept to done plus the WB pulses.
   task automatic issue(input logic [15:0] ins, output int lat, output logic ill,
                        output logic shw, output logic [7:0] sdata);
      int n;
      n = 0;
      instr       = ins;
      instr_valid = 1'b1;
      while (!instr_ready && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      @(posedge clock); #1;
      instr_valid = 1'b0;
      lat = 1;
      @(negedge clock); #1;
      chk("alu_op_launch", 32'(alu_op), 32'(ins[15:11]));
      chk("alu_im_launch", 32'(alu_im), 32'(ins[4:2]));
      @(posedge clock); #1;
      lat = 2;
      while (!done && lat < 20) begin
         @(posedge clock); #1;
         lat++;
      end
      ill   = illegal;
      shw   = show_valid;
      sdata = show_data;
      @(posedge clock); #1;
      chk("done_width", 32'(done), 32'(0));
      chk("pulse_width", 32'({illegal, show_valid}), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic        ill, shw;
      logic [7:0]  sd, rv;

      vecs[0]  = '{mk(5'd1,  3'd1, 3'd2, 3'd0, 2'b00), 3'd1, 8'h80, 4'b0011, 1'b0, 1'b0, 8'h00};
      vecs[1]  = '{mk(5'd3,  3'd3, 3'd4, 3'd0, 2'b00), 3'd3, 8'h00, 4'b0100, 1'b0, 1'b0, 8'h00};
      vecs[2]  = '{mk(5'd6,  3'd5, 3'd1, 3'd0, 2'b00), 3'd5, 8'h80, 4'b0100, 1'b0, 1'b0, 8'h00};
      vecs[3]  = '{mk(5'd31, 3'd1, 3'd0, 3'd0, 2'b00), 3'd1, 8'h80, 4'b0100, 1'b0, 1'b1, 8'h80};
      vecs[4]  = '{mk(5'd16, 3'd1, 3'd2, 3'd0, 2'b00), 3'd1, 8'h80, 4'b0100, 1'b1, 1'b0, 8'h00};
      vecs[5]  = '{mk(5'd0,  3'd1, 3'd2, 3'd0, 2'b00), 3'd1, 8'h80, 4'b0100, 1'b0, 1'b0, 8'h00};
      vecs[6]  = '{mk(5'd8,  3'd2, 3'd0, 3'd0, 2'b11), 3'd2, 8'hFE, 4'b0100, 1'b0, 1'b0, 8'h00};
      vecs[7]  = '{mk(5'd2,  3'd2, 3'd5, 3'd0, 2'b00), 3'd2, 8'h80, 4'b0010, 1'b0, 1'b0, 8'h00};
      vecs[8]  = '{mk(5'd5,  3'd2, 3'd2, 3'd0, 2'b00), 3'd2, 8'h00, 4'b0100, 1'b0, 1'b0, 8'h00};
      vecs[9]  = '{mk(5'd7,  3'd1, 3'd2, 3'd0, 2'b00), 3'd1, 8'h80, 4'b0100, 1'b1, 1'b0, 8'h00};
      vecs[10] = '{mk(5'd1,  3'd3, 3'd5, 3'd0, 2'b00), 3'd3, 8'h80, 4'b0010, 1'b0, 1'b0, 8'h00};
      vecs[11] = '{mk(5'd9,  3'd5, 3'd0, 3'd1, 2'b00), 3'd5, 8'h00, 4'b1100, 1'b0, 1'b0, 8'h00};

      reset       = 1'b1;
      instr       = '0;
      instr_valid = 1'b0;
      reg_wr_en   = 1'b0;
      reg_wr_addr = '0;
      reg_wr_data = '0;
      reg_rd_addr = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state
      chk("rst_ready", 32'(instr_ready), 32'(1));
      chk("rst_flags", 32'(flags), 32'(0));
      chk("rst_pulses", 32'({done, illegal, show_valid}), 32'(0));
      chk("rst_show_data", 32'(show_data), 32'(0));
      chk("rst_alu", 32'({alu_op, alu_in1, alu_in2, alu_im}), 32'(0));
      for (int i = 0; i < 8; i++) begin
         read_reg(3'(i), rv);
         chk("rst_rf", 32'(rv), 32'(0));
      end

      preload(3'd1, 8'h7F);
      preload(3'd2, 8'h01);
      preload(3'd3, 8'h05);
      preload(3'd4, 8'h05);

      // Table-driven instruction sequence; each row depends on the previous results.
      for (int v = 0; v < 12; v++) begin
         issue(vecs[v].ins, lat, ill, shw, sd);
         chk($sformatf("v%0d_latency", v), 32'(lat), 32'(2));
         chk($sformatf("v%0d_illegal", v), 32'(ill), 32'(vecs[v].ill));
         chk($sformatf("v%0d_show_valid", v), 32'(shw), 32'(vecs[v].shw));
         if (vecs[v].shw) chk($sformatf("v%0d_show_data", v), 32'(sd), 32'(vecs[v].sdata));
         read_reg(vecs[v].addr, rv);
         chk($sformatf("v%0d_reg", v), 32'(rv), 32'(vecs[v].val));
         chk($sformatf("v%0d_flags", v), 32'(flags), 32'(vecs[v].flg));
         chk($sformatf("v%0d_alu_op_nop", v), 32'(alu_op), 32'(0));
      end

      // Preload outside IDLE is ignored.
      instr       = mk(5'd0, 3'd0, 3'd0, 3'd0, 2'b00);
      instr_valid = 1'b1;
      @(posedge clock); #1;
      instr_valid = 1'b0;
      reg_wr_en   = 1'b1;
      reg_wr_addr = 3'd6;
      reg_wr_data = 8'hAA;
      @(posedge clock); #1;
      chk("busy_done", 32'(done), 32'(1));
      @(posedge clock); #1;
      reg_wr_en = 1'b0;
      read_reg(3'd6, rv);
      chk("busy_preload_ignored", 32'(rv), 32'(0));

      // Back-to-back dependent ADDs with instr_valid held; accept beats a same-cycle preload.
      preload(3'd1, 8'h01);
      preload(3'd2, 8'h01);
      instr       = mk(5'd1, 3'd1, 3'd2, 3'd0, 2'b00);
      instr_valid = 1'b1;
      @(posedge clock); #1;
      chk("b2b_ready_exec", 32'(instr_ready), 32'(0));
      @(posedge clock); #1;
      chk("b2b_ready_wb", 32'(instr_ready), 32'(0));
      chk("b2b_done1", 32'(done), 32'(1));
      reg_wr_en   = 1'b1;
      reg_wr_addr = 3'd1;
      reg_wr_data = 8'h55;
      @(posedge clock); #1;
      chk("b2b_ready_idle", 32'(instr_ready), 32'(1));
      @(posedge clock); #1;
      chk("b2b_second_accept", 32'(instr_ready), 32'(0));
      instr_valid = 1'b0;
      reg_wr_en   = 1'b0;
      @(posedge clock); #1;
      chk("b2b_done2", 32'(done), 32'(1));
      @(posedge clock); #1;
      read_reg(3'd1, rv);
      chk("b2b_r1", 32'(rv), 32'(8'h03));

      // Reset in EXEC aborts without writeback.
      preload(3'd7, 8'h33);
      instr       = mk(5'd1, 3'd1, 3'd2, 3'd0, 2'b00);
      instr_valid = 1'b1;
      @(posedge clock); #1;
      instr_valid = 1'b0;
      chk("abort_in_exec", 32'(instr_ready), 32'(0));
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      chk("abort_done", 32'(done), 32'(0));
      chk("abort_ready", 32'(instr_ready), 32'(1));
      chk("abort_flags", 32'(flags), 32'(0));
      for (int i = 0; i < 8; i++) begin
         read_reg(3'(i), rv);
         chk("abort_rf", 32'(rv), 32'(0));
      end
      @(negedge clock); #1;
      chk("abort_alu_op", 32'(alu_op), 32'(0));
      @(posedge clock); #1;
      chk("abort_no_pulse", 32'({done, illegal, show_valid}), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
